// File: rtl/mc6502_bus_responder.sv
// mc6502_bus_responder: bus target between an MC6502 core and a 64Kx8 RAM.
// It writes the reset vector into RAM, then releases the CPU from reset.
// While the CPU runs, it arbitrates the RAM port, adds RAM read wait states
// through RDY, and serves a two-byte I/O window (output port and cycle
// counter). It halts the CPU when an opcode fetch returns $FF.
module mc6502_bus_responder #(
    parameter logic [15:0] RESET_VECTOR = 16'h0000,
    parameter int          WAIT_STATES  = 0,
    parameter logic [15:0] IO_ADDR      = 16'hFFF0
) (
    input  logic        clk_1mhz,
    input  logic        rst_x,
    input  logic [15:0] i_ab,
    input  logic        i_rw,
    input  logic        i_sync,
    input  logic [7:0]  i_db_w,
    output logic [7:0]  o_db_r,
    output logic        o_rdy,
    output logic        o_cpu_rst_x,
    output logic [15:0] o_ram_addr,
    output logic [7:0]  o_ram_data,
    output logic        o_ram_write_x,
    input  logic [7:0]  i_ram_data,
    output logic [7:0]  o_port,
    output logic [15:0] o_cycle,
    output logic        o_init_done,
    output logic        o_halt
);

    localparam logic [3:0]  WS     = 4'(WAIT_STATES);
    localparam logic [15:0] IO_HI  = IO_ADDR + 16'd1;
    localparam logic [15:0] VEC_LO = 16'hFFFC;
    localparam logic [15:0] VEC_HI = 16'hFFFD;

    typedef enum logic [2:0] {
        S_INIT_LO,
        S_INIT_HI,
        S_RELEASE,
        S_RUN,
        S_HALT
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [15:0] cycle_q, cycle_d;
    logic [7:0]  port_q, port_d;
    logic        cpu_rst_q, cpu_rst_d;

    logic io_lo, io_hi, io_acc, ram_read;

    assign io_lo    = (i_ab == IO_ADDR);
    assign io_hi    = (i_ab == IO_HI);
    assign io_acc   = io_lo | io_hi;
    // A RAM read is the only access that is stretched by wait states.
    assign ram_read = i_rw & ~io_acc;

    assign o_cpu_rst_x = cpu_rst_q;
    assign o_port      = port_q;
    assign o_cycle     = cycle_q;

    // State register: async active-low reset returns to the vector load.
    always_ff @(posedge clk_1mhz or negedge rst_x) begin
        if (!rst_x) begin
            state_q <= S_INIT_LO;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: fixed init sequence, then RUN until a $FF fetch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT_LO: state_d = S_INIT_HI;
            S_INIT_HI: state_d = S_RELEASE;
            S_RELEASE: state_d = S_RUN;
            S_RUN: begin
                if (i_sync && i_rw && o_rdy && (o_db_r == 8'hFF)) begin
                    state_d = S_HALT;
                end
            end
            S_HALT:    state_d = S_HALT;
            default:   state_d = S_INIT_LO;
        endcase
    end

    // Output logic: RAM port mux, RDY generation and status flags.
    always_comb begin
        o_ram_addr    = i_ab;
        o_ram_data    = i_db_w;
        o_ram_write_x = 1'b1;
        o_rdy         = 1'b1;
        o_init_done   = 1'b0;
        o_halt        = 1'b0;
        case (state_q)
            S_INIT_LO: begin
                o_ram_addr    = VEC_LO;
                o_ram_data    = RESET_VECTOR[7:0];
                o_ram_write_x = 1'b0;
            end
            S_INIT_HI: begin
                o_ram_addr    = VEC_HI;
                o_ram_data    = RESET_VECTOR[15:8];
                o_ram_write_x = 1'b0;
            end
            S_RUN: begin
                // I/O addresses never reach RAM as writes.
                o_ram_write_x = io_acc ? 1'b1 : i_rw;
                o_rdy         = ram_read ? (wcnt_q == WS) : 1'b1;
                o_init_done   = 1'b1;
            end
            S_HALT: begin
                o_rdy       = 1'b0;
                o_init_done = 1'b1;
                o_halt      = 1'b1;
            end
            default: begin
                o_ram_write_x = 1'b1;
            end
        endcase
    end

    // Read data mux: I/O window returns counter bytes, otherwise RAM passes through.
    always_comb begin
        if (io_lo) begin
            o_db_r = cycle_q[7:0];
        end else if (io_hi) begin
            o_db_r = cycle_q[15:8];
        end else begin
            o_db_r = i_ram_data;
        end
    end

    // Datapath next-state: wait counter, saturating cycle counter, port, CPU reset.
    always_comb begin
        wcnt_d    = 4'd0;
        cycle_d   = cycle_q;
        port_d    = port_q;
        cpu_rst_d = cpu_rst_q | (state_q == S_RELEASE);
        if (state_q == S_RUN) begin
            if (ram_read && (wcnt_q < WS)) begin
                wcnt_d = wcnt_q + 4'd1;
            end
            if (cycle_q != 16'hFFFF) begin
                cycle_d = cycle_q + 16'd1;
            end
            if (!i_rw && io_lo) begin
                port_d = i_db_w;
            end
        end
    end

    // Datapath registers, all cleared by the async reset.
    always_ff @(posedge clk_1mhz or negedge rst_x) begin
        if (!rst_x) begin
            wcnt_q    <= 4'd0;
            cycle_q   <= 16'd0;
            port_q    <= 8'd0;
            cpu_rst_q <= 1'b0;
        end else begin
            wcnt_q    <= wcnt_d;
            cycle_q   <= cycle_d;
            port_q    <= port_d;
            cpu_rst_q <= cpu_rst_d;
        end
    end

endmodule
